fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: stall  input  1  decode hazard hold; freeze PC and F/D latch.
REQ-004 SHALL have port: redirect  input  1  taken branch/jump/bex flag from execute stage.
REQ-005 SHALL have port: redirect_pc  input  32  target PC from execute stage, valid when redirect=1.
REQ-006 SHALL have port: halt_req  input  1  stop fetching until reset.
REQ-007 SHALL have port: imem_data  input  32  instruction word at imem_addr, combinational read.
REQ-008 SHALL have port: imem_addr  output  12  instruction memory address, equal to pc[11:0].
REQ-009 SHALL have port: pc  output  32  current fetch PC.
REQ-010 SHALL have port: fd_pc  output  32  PC+1 of the instruction in the F/D latch.
REQ-011 SHALL have port: fd_ir  output  32  instruction in the F/D latch; 32'h0 is NOP.
REQ-012 SHALL have port: fd_valid  output  1  F/D latch holds a real instruction.
REQ-013 SHALL have port: dx_flush  output  1  combinational; kill the instruction entering D/X.
REQ-014 SHALL have port: state  output  2  FSM state: BOOT=00, RUN=01, HALT=10.
REQ-015 SHALL have port: redirect_count  output  16  number of accepted redirects.
REQ-016 SHALL have port: stall_count  output  16  number of stall cycles.

Function
REQ-017 SHALL implement a 3-state FSM: BOOT, RUN, HALT.
REQ-018 SHALL hold BOOT for exactly one cycle after reset release, with no fetch and no state change other than BOOT->RUN.
REQ-019 SHALL use this per-edge priority in RUN: redirect > halt_req > stall > normal fetch.
REQ-020 SHALL, in RUN with redirect=1: pc<=redirect_pc; fd_ir<=0; fd_pc<=0; fd_valid<=0; redirect_count increments; stall and halt_req that cycle are ignored.
REQ-021 SHALL, in RUN with halt_req=1 and redirect=0: go to HALT; fd_ir<=0; fd_valid<=0; pc holds.
REQ-022 SHALL, in RUN with stall=1 and redirect=0 and halt_req=0: hold pc, fd_pc, fd_ir and fd_valid; stall_count increments.
REQ-023 SHALL, on a normal fetch: pc<=pc+1; fd_ir<=imem_data; fd_pc<=pc+1; fd_valid<=1.
REQ-024 SHALL compute pc+1 as 32-bit modulo; 32'hFFFFFFFF wraps to 0 with no flag.
REQ-025 SHALL drive dx_flush = redirect when state=RUN, and 0 otherwise (no registered delay).
REQ-026 SHALL, in HALT, ignore redirect, stall and halt_req; hold all registers; exit HALT only through reset.
REQ-027 SHALL, in BOOT, ignore redirect, stall and halt_req; dx_flush=0.
REQ-028 SHALL saturate redirect_count and stall_count at 16'hFFFF with no wrap.
REQ-029 SHALL give the instruction after a redirect a redirect penalty of one F/D bubble plus the D/X kill, and fetch the first target instruction in the cycle after the redirect edge.

Reset
REQ-030 SHALL, on reset_n=0 at any time including mid-redirect or in HALT, asynchronously force: pc=0, fd_pc=0, fd_ir=0, fd_valid=0, state=BOOT, redirect_count=0, stall_count=0.
REQ-031 SHALL give imem_addr=0 and dx_flush=0 while reset is asserted.

Verification
REQ-032 Release reset with imem returning 32'hA0 at addr 0 and 32'hA1 at addr 1 -> BOOT for 1 cycle; then fd_ir=A0, fd_pc=1, pc=1; next cycle fd_ir=A1, fd_pc=2.
REQ-033 At pc=5, assert redirect=1 with redirect_pc=32'h40 for 1 cycle -> dx_flush=1 that cycle; next edge pc=0x40, fd_ir=0, fd_valid=0, redirect_count=1; the following edge fd_ir=mem[0x40], fd_pc=0x41.
REQ-034 Assert stall for 3 cycles at pc=7 -> pc, fd_ir and fd_pc hold for 3 edges; stall_count=3; fetch resumes at 7.
REQ-035 Assert redirect, stall and halt_req together, redirect_pc=0x10 -> redirect wins: pc=0x10, state stays RUN, stall_count unchanged; then halt_req alone -> HALT; a later redirect has no effect and pc holds.
REQ-036 Preload pc=32'hFFFFFFFF via redirect, then fetch -> pc=0, fd_pc=0; drive 65540 stall cycles -> stall_count=FFFF.
REQ-037 Assert reset_n=0 asynchronously mid-cycle while in HALT with nonzero counters -> all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: execute-side controls, imem port, F/D latch outputs.
// master = surrounding pipeline, slave = fetch_stage.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] imem_data;
  logic [11:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] fd_pc;
  logic [31:0] fd_ir;
  logic        fd_valid;
  logic        dx_flush;
  logic [1:0]  state;
  logic [15:0] redirect_count;
  logic [15:0] stall_count;

  modport slave (
    input  stall, redirect, redirect_pc,
    input  halt_req, imem_data,
    output imem_addr, pc, fd_pc, fd_ir,
    output fd_valid, dx_flush, state,
    output redirect_count, stall_count
  );

  modport master (
    output stall, redirect, redirect_pc,
    output halt_req, imem_data,
    input  imem_addr, pc, fd_pc, fd_ir,
    input  fd_valid, dx_flush, state,
    input  redirect_count, stall_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, F/D latch, BOOT/RUN/HALT FSM, counters.
// Ports: clock, reset_n (async low), bus (fetch_stage_if.slave).
module fetch_stage (
  input  logic clock,
  input  logic reset_n,
  fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] fd_pc_q;
  logic [31:0] fd_ir_q;
  logic        fd_valid_q;
  logic [15:0] rc_q;
  logic [15:0] sc_q;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd1;

  assign bus.imem_addr      = pc_q[11:0];
  assign bus.pc             = pc_q;
  assign bus.fd_pc          = fd_pc_q;
  assign bus.fd_ir          = fd_ir_q;
  assign bus.fd_valid       = fd_valid_q;
  assign bus.state          = state_q;
  assign bus.redirect_count = rc_q;
  assign bus.stall_count    = sc_q;
  // Kill D/X in the same cycle the redirect is seen.
  assign bus.dx_flush = bus.redirect &&
                        (state_q == RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      fd_pc_q    <= '0;
      fd_ir_q    <= '0;
      fd_valid_q <= 1'b0;
      rc_q       <= '0;
      sc_q       <= '0;
    end else begin
      unique case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (bus.redirect) begin
            pc_q       <= bus.redirect_pc;
            fd_pc_q    <= '0;
            fd_ir_q    <= '0;
            fd_valid_q <= 1'b0;
            if (rc_q != 16'hFFFF)
              rc_q <= rc_q + 16'd1;
          end else if (bus.halt_req) begin
            state_q    <= HALT;
            fd_ir_q    <= '0;
            fd_valid_q <= 1'b0;
          end else if (bus.stall) begin
            if (sc_q != 16'hFFFF)
              sc_q <= sc_q + 16'd1;
          end else begin
            pc_q       <= pc_inc;
            fd_pc_q    <= pc_inc;
            fd_ir_q    <= bus.imem_data;
            fd_valid_q <= 1'b1;
          end
        end
        HALT: state_q <= HALT;
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a
// behavioural reference model.
module tb_fetch_stage;

  logic clock;
  logic reset_n;
  fetch_stage_if bus();

  fetch_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] mem [0:4095];
  assign bus.imem_data = mem[bus.imem_addr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  localparam int S_BOOT = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;

  int          total = 0;
  int          bad   = 0;
  int          m_state;
  logic [31:0] m_pc, m_fd_pc, m_fd_ir;
  logic        m_valid;
  int          m_rc, m_sc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_BOOT;
    m_pc    = 0;
    m_fd_pc = 0;
    m_fd_ir = 0;
    m_valid = 0;
    m_rc    = 0;
    m_sc    = 0;
  endtask

  task automatic chk_all(input string t);
    chk({t, ".pc"}, bus.pc, m_pc);
    chk({t, ".addr"}, {20'b0, bus.imem_addr},
        {20'b0, m_pc[11:0]});
    if (m_state != S_HALT)
      chk({t, ".fd_pc"}, bus.fd_pc, m_fd_pc);
    chk({t, ".fd_ir"}, bus.fd_ir, m_fd_ir);
    chk({t, ".valid"}, {31'b0, bus.fd_valid},
        {31'b0, m_valid});
    chk({t, ".state"}, {30'b0, bus.state},
        m_state);
    chk({t, ".rc"}, {16'b0, bus.redirect_count},
        m_rc);
    chk({t, ".sc"}, {16'b0, bus.stall_count},
        m_sc);
  endtask

  // One cycle: drive, check flush, clock, check.
  task automatic step(input string t,
                      input logic rd,
                      input logic [31:0] rpc,
                      input logic hl,
                      input logic st);
    logic ef;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.halt_req    = hl;
    bus.stall       = st;
    #1;
    ef = (m_state == S_RUN) && rd;
    chk({t, ".flush"}, {31'b0, bus.dx_flush},
        {31'b0, ef});
    @(posedge clock);
    if (m_state == S_BOOT) begin
      m_state = S_RUN;
    end else if (m_state == S_RUN) begin
      if (rd) begin
        m_pc    = rpc;
        m_fd_ir = 0;
        m_fd_pc = 0;
        m_valid = 0;
        m_rc    = (m_rc < 65535) ? m_rc + 1 : 65535;
      end else if (hl) begin
        m_state = S_HALT;
        m_fd_ir = 0;
        m_valid = 0;
      end else if (st) begin
        m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
      end else begin
        m_fd_ir = mem[m_pc[11:0]];
        m_pc    = m_pc + 1;
        m_fd_pc = m_pc;
        m_valid = 1;
      end
    end
    #1;
    chk_all(t);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_req    = 1'b0;
    bus.stall       = 1'b0;
    for (int i = 0; i < 4096; i++)
      mem[i] = $urandom;
    mem[0] = 32'hA0;
    mem[1] = 32'hA1;
    model_reset();

    #3;
    chk_all("rst");
    bus.redirect = 1'b1;
    #1;
    chk("rst.flush", {31'b0, bus.dx_flush}, 32'd0);
    bus.redirect = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // BOOT ignores everything
    step("boot", 1'b1, 32'h40, 1'b1, 1'b1);
    step("f0", 0, 0, 0, 0);
    chk("f0.ir", bus.fd_ir, 32'hA0);
    chk("f0.pc", bus.fd_pc, 32'd1);
    step("f1", 0, 0, 0, 0);
    chk("f1.ir", bus.fd_ir, 32'hA1);
    chk("f1.pc", bus.fd_pc, 32'd2);
    step("f2", 0, 0, 0, 0);
    step("f3", 0, 0, 0, 0);
    step("f4", 0, 0, 0, 0);
    chk("at5", bus.pc, 32'd5);

    step("redir", 1, 32'h40, 0, 0);
    chk("redir.pc", bus.pc, 32'h40);
    step("tgt", 0, 0, 0, 0);
    chk("tgt.ir", bus.fd_ir, mem[12'h40]);
    chk("tgt.pc", bus.fd_pc, 32'h41);

    step("to7", 1, 32'd7, 0, 0);
    step("st1", 0, 0, 0, 1);
    step("st2", 0, 0, 0, 1);
    step("st3", 0, 0, 0, 1);
    chk("st.cnt", {16'b0, bus.stall_count}, 32'd3);
    step("res", 0, 0, 0, 0);
    chk("res.ir", bus.fd_ir, mem[7]);

    for (int i = 0; i < 1500; i++) begin
      step("rnd", ($urandom_range(0, 7) == 0),
           $urandom,
           1'b0,
           ($urandom_range(0, 3) == 0));
    end

    step("all3", 1, 32'h10, 1, 1);
    chk("all3.pc", bus.pc, 32'h10);
    step("halt", 0, 0, 1, 0);
    chk("halt.st", {30'b0, bus.state}, 32'd2);
    step("h.rd", 1, 32'h80, 0, 1);
    chk("h.pc", bus.pc, 32'h10);
    for (int i = 0; i < 5; i++)
      step("h.rnd", $urandom_range(0, 1), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1));

    // async reset mid-cycle while halted
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("arst");
    chk("arst.flush", {31'b0, bus.dx_flush}, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    step("boot2", 0, 0, 0, 0);
    step("wrap.rd", 1, 32'hFFFFFFFF, 0, 0);
    step("wrap", 0, 0, 0, 0);
    chk("wrap.pc", bus.pc, 32'd0);
    chk("wrap.fdpc", bus.fd_pc, 32'd0);

    bus.stall = 1'b1;
    repeat (65540) @(posedge clock);
    #1;
    m_sc = 65535;
    chk_all("sat");
    chk("sat.sc", {16'b0, bus.stall_count},
        32'h0000FFFF);
    bus.stall = 1'b0;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
